// File: rtl/lq_sample_ctrl_if.sv
// lq_sample_ctrl_if
//   Groups every non-clock, non-reset signal of lq_sample_ctrl.
//   master: the pipeline/software side. It drives the load events and rd_req.
//   slave : the sampling controller. It drives busy and the rd_* snapshot.
//   Signals:
//     en, timestamp           sample permission and free-running coarse time
//     disp_*, exec_*, ret_*   load dispatch / execute / retire events
//     flush                   pipeline flush
//     rd_req, rd_valid        one-shot read handshake
//     rd_*                    statistics snapshot returned by a read
interface lq_sample_ctrl_if #(
  parameter int DUR_W = 10,
  parameter int IDX_W = 6,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
);
  logic             en;
  logic [DUR_W-1:0] timestamp;
  logic             disp_valid;
  logic [IDX_W-1:0] disp_idx;
  logic             exec_valid;
  logic [IDX_W-1:0] exec_idx;
  logic             ret_valid;
  logic [IDX_W-1:0] ret_idx;
  logic             flush;
  logic             rd_req;
  logic             busy;
  logic             rd_valid;
  logic [ACC_W-1:0] rd_sum_dp;
  logic [ACC_W-1:0] rd_sum_end;
  logic [DUR_W-1:0] rd_max_end;
  logic [CNT_W-1:0] rd_samples;
  logic [CNT_W-1:0] rd_aborts;
  logic             rd_sat;

  modport master (
    output en, timestamp, disp_valid, disp_idx, exec_valid, exec_idx,
           ret_valid, ret_idx, flush, rd_req,
    input  busy, rd_valid, rd_sum_dp, rd_sum_end, rd_max_end,
           rd_samples, rd_aborts, rd_sat
  );

  modport slave (
    input  en, timestamp, disp_valid, disp_idx, exec_valid, exec_idx,
           ret_valid, ret_idx, flush, rd_req,
    output busy, rd_valid, rd_sum_dp, rd_sum_end, rd_max_end,
           rd_samples, rd_aborts, rd_sat
  );
endinterface

// File: rtl/lq_sample_ctrl.sv
// lq_sample_ctrl
//   Load-queue residency sampler. Every INTERVAL enabled idle cycles it arms,
//   latches the next dispatched load (index + timestamp), follows it to
//   execute and retire, and accumulates dispatch->exec and dispatch->retire
//   durations into saturating statistics. A one-cycle rd_req snapshots the
//   post-update statistics into the rd_* registers and clears them.
//   Ports:
//     clk    single clock
//     reset  synchronous, active-high
//     bus    lq_sample_ctrl_if.slave (events in, busy + read snapshot out)
//   Optional feature macro: LQ_SAMPLE_TIMEOUT_EN
//     defined   : a tracked sample aborts after TIMEOUT cycles without a match
//     undefined : a lost entry stalls in WAIT_* until flush or reset
module lq_sample_ctrl #(
  parameter int DUR_W    = 10,
  parameter int IDX_W    = 6,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 16,
  parameter int INTERVAL = 256,
  parameter int TIMEOUT  = 1023
) (
  input logic             clk,
  input logic             reset,
  lq_sample_ctrl_if.slave bus
);

  localparam int IVL_W = $clog2(INTERVAL);
  localparam int AW1   = ACC_W + 1;
  localparam logic [IVL_W-1:0] IVL_RELOAD = IVL_W'(INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_EXEC, WAIT_RET, COMMIT} state_t;

  state_t           state;
  logic [IVL_W-1:0] ivl_cnt;
  logic [DUR_W-1:0] start;
  logic [IDX_W-1:0] mon_idx;
  logic [DUR_W-1:0] dur_dp;
  logic [DUR_W-1:0] dur_end;

  logic [ACC_W-1:0] sum_dp, sum_end, snap_sum_dp, snap_sum_end;
  logic [DUR_W-1:0] max_end, snap_max_end;
  logic [CNT_W-1:0] samples, aborts, snap_samples, snap_aborts;
  logic             sat, snap_sat, snap_valid;

  logic [ACC_W-1:0] sum_dp_nxt, sum_end_nxt;
  logic [DUR_W-1:0] max_end_nxt;
  logic [CNT_W-1:0] samples_nxt, aborts_nxt;
  logic             sat_nxt;
  logic [AW1-1:0]   sum_dp_add, sum_end_add;

  logic             exec_hit, ret_hit, timed_out, abort_evt, commit_evt;
  logic [DUR_W-1:0] elapsed;

  assign exec_hit   = bus.exec_valid && (bus.exec_idx == mon_idx);
  assign ret_hit    = bus.ret_valid && (bus.ret_idx == mon_idx);
  // Modular subtraction gives the right duration across a timestamp wrap.
  assign elapsed    = bus.timestamp - start;
  assign commit_evt = (state == COMMIT);

`ifdef LQ_SAMPLE_TIMEOUT_EN
  localparam int TRK_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TRK_W-1:0] trk_cnt;
  // trk_cnt is 0 in the first WAIT_EXEC cycle, so the abort lands TIMEOUT
  // cycles after the sample entered WAIT_EXEC.
  assign timed_out = ((state == WAIT_EXEC) || (state == WAIT_RET)) &&
                     (trk_cnt == TRK_W'(TIMEOUT - 1));
`else
  // Nothing ever times out here; TIMEOUT only matters with the tracking counter.
  assign timed_out = 1'b0 && (TIMEOUT > 0);
`endif

  // Flush beats any same-cycle match; a match beats a same-cycle timeout.
  always_comb begin
    abort_evt = 1'b0;
    case (state)
      ARM:       abort_evt = bus.flush;
      WAIT_EXEC: abort_evt = bus.flush || (!exec_hit && (ret_hit || timed_out));
      WAIT_RET:  abort_evt = bus.flush || (!ret_hit && timed_out);
      default:   abort_evt = 1'b0;
    endcase
  end

  assign sum_dp_add  = {1'b0, sum_dp} + AW1'(dur_dp);
  assign sum_end_add = {1'b0, sum_end} + AW1'(dur_end);

  // Post-update statistics for this cycle; a read snapshots exactly these.
  always_comb begin
    sum_dp_nxt  = sum_dp;
    sum_end_nxt = sum_end;
    max_end_nxt = max_end;
    samples_nxt = samples;
    aborts_nxt  = aborts;
    if (commit_evt) begin
      sum_dp_nxt  = sum_dp_add[ACC_W] ? '1 : sum_dp_add[ACC_W-1:0];
      sum_end_nxt = sum_end_add[ACC_W] ? '1 : sum_end_add[ACC_W-1:0];
      samples_nxt = (&samples) ? samples : samples + 1'b1;
      if (dur_end > max_end) max_end_nxt = dur_end;
    end
    if (abort_evt) aborts_nxt = (&aborts) ? aborts : aborts + 1'b1;
    sat_nxt = sat | (&sum_dp_nxt) | (&sum_end_nxt) | (&samples_nxt) | (&aborts_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ivl_cnt      <= IVL_RELOAD;
      start        <= '0;
      mon_idx      <= '0;
      dur_dp       <= '0;
      dur_end      <= '0;
      sum_dp       <= '0;
      sum_end      <= '0;
      max_end      <= '0;
      samples      <= '0;
      aborts       <= '0;
      sat          <= 1'b0;
      snap_sum_dp  <= '0;
      snap_sum_end <= '0;
      snap_max_end <= '0;
      snap_samples <= '0;
      snap_aborts  <= '0;
      snap_sat     <= 1'b0;
      snap_valid   <= 1'b0;
`ifdef LQ_SAMPLE_TIMEOUT_EN
      trk_cnt      <= '0;
`endif
    end else begin
      if (abort_evt || commit_evt) begin
        state   <= IDLE;
        ivl_cnt <= IVL_RELOAD;
      end else begin
        case (state)
          IDLE: begin
            if (bus.en) begin
              if (ivl_cnt == '0) begin
                state   <= ARM;
                ivl_cnt <= IVL_RELOAD;
              end else begin
                ivl_cnt <= ivl_cnt - 1'b1;
              end
            end
          end
          ARM: begin
            if (!bus.en) begin
              state <= IDLE;
            end else if (bus.disp_valid) begin
              start   <= bus.timestamp;
              mon_idx <= bus.disp_idx;
              state   <= WAIT_EXEC;
            end
          end
          WAIT_EXEC: begin
            if (exec_hit) begin
              dur_dp <= elapsed;
              if (ret_hit) begin
                dur_end <= elapsed;
                state   <= COMMIT;
              end else begin
                state <= WAIT_RET;
              end
            end
          end
          WAIT_RET: begin
            // Replayed exec matches are ignored here.
            if (ret_hit) begin
              dur_end <= elapsed;
              state   <= COMMIT;
            end
          end
          default: state <= IDLE;
        endcase
      end

`ifdef LQ_SAMPLE_TIMEOUT_EN
      if ((state == WAIT_EXEC) || (state == WAIT_RET)) trk_cnt <= trk_cnt + 1'b1;
      else trk_cnt <= '0;
`endif

      snap_valid <= bus.rd_req;
      if (bus.rd_req) begin
        snap_sum_dp  <= sum_dp_nxt;
        snap_sum_end <= sum_end_nxt;
        snap_max_end <= max_end_nxt;
        snap_samples <= samples_nxt;
        snap_aborts  <= aborts_nxt;
        snap_sat     <= sat_nxt;
        sum_dp       <= '0;
        sum_end      <= '0;
        max_end      <= '0;
        samples      <= '0;
        aborts       <= '0;
        sat          <= 1'b0;
      end else begin
        sum_dp  <= sum_dp_nxt;
        sum_end <= sum_end_nxt;
        max_end <= max_end_nxt;
        samples <= samples_nxt;
        aborts  <= aborts_nxt;
        sat     <= sat_nxt;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.rd_valid   = snap_valid;
  assign bus.rd_sum_dp  = snap_sum_dp;
  assign bus.rd_sum_end = snap_sum_end;
  assign bus.rd_max_end = snap_max_end;
  assign bus.rd_samples = snap_samples;
  assign bus.rd_aborts  = snap_aborts;
  assign bus.rd_sat     = snap_sat;

endmodule

// File: tb/tb_lq_sample_ctrl.sv
// tb_lq_sample_ctrl
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model predicts every read snapshot (pushed into a queue) and
//   the busy flag each cycle; a separate monitor pops on rd_valid.
module tb_lq_sample_ctrl;

  localparam int DUR_W    = 10;
  localparam int IDX_W    = 6;
  localparam int ACC_W    = 10;
  localparam int CNT_W    = 4;
  localparam int INTERVAL = 4;
  localparam int TIMEOUT  = 16;
  localparam int MASK     = (1 << DUR_W) - 1;
  localparam int ACC_MAX  = (1 << ACC_W) - 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef LQ_SAMPLE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk;
  logic reset;

  lq_sample_ctrl_if #(.DUR_W(DUR_W), .IDX_W(IDX_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  lq_sample_ctrl #(
    .DUR_W(DUR_W), .IDX_W(IDX_W), .ACC_W(ACC_W), .CNT_W(CNT_W),
    .INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sum_dp;
    int sum_end;
    int max_end;
    int samples;
    int aborts;
    bit sat;
  } snap_t;

  snap_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int ts_now     = 0;

  // Reference model: a sample "in flight" with its idle wait, arming flag
  // and measured durations; statistics kept as plain saturating integers.
  int m_wait;
  bit m_armed, m_track, m_exec, m_commit;
  int m_idx, m_start, m_dp, m_end, m_age;
  int a_sum_dp, a_sum_end, a_max, a_samples, a_aborts;
  bit a_sat;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int satAdd(input int a, input int b, input int maxv);
    return (a + b > maxv) ? maxv : a + b;
  endfunction

  function automatic void modelReset();
    m_wait = INTERVAL - 1;
    m_armed = 0; m_track = 0; m_exec = 0; m_commit = 0;
    m_idx = 0; m_start = 0; m_dp = 0; m_end = 0; m_age = 0;
    a_sum_dp = 0; a_sum_end = 0; a_max = 0; a_samples = 0; a_aborts = 0; a_sat = 0;
  endfunction

  function automatic void modelStep(input bit en, input bit dv, input int di, input bit xv, input int xi,
                                    input bit rv, input int ri, input bit fl, input bit rd, input int ts);
    bit ab, xm, rm, to;
    snap_t s;
    ab = 0;
    if (m_commit) begin
      m_commit  = 0;
      a_sum_dp  = satAdd(a_sum_dp, m_dp, ACC_MAX);
      a_sum_end = satAdd(a_sum_end, m_end, ACC_MAX);
      a_samples = satAdd(a_samples, 1, CNT_MAX);
      if (m_end > a_max) a_max = m_end;
      m_wait = INTERVAL - 1;
    end else if (m_track) begin
      xm = xv && (xi == m_idx);
      rm = rv && (ri == m_idx);
      to = TIMEOUT_ON && (m_age >= TIMEOUT - 1);
      if (fl) ab = 1;
      else if (!m_exec) begin
        if (xm) begin
          m_dp = (ts - m_start) & MASK;
          m_exec = 1;
          if (rm) begin m_end = m_dp; m_track = 0; m_commit = 1; end
        end else if (rm || to) ab = 1;
      end else if (rm) begin
        m_end = (ts - m_start) & MASK; m_track = 0; m_commit = 1;
      end else if (to) ab = 1;
      m_age++;
    end else if (m_armed) begin
      if (fl) ab = 1;
      else if (!en) m_armed = 0;
      else if (dv) begin
        m_armed = 0; m_track = 1; m_exec = 0; m_idx = di; m_start = ts; m_age = 0;
      end
    end else if (en) begin
      if (m_wait == 0) begin m_armed = 1; m_wait = INTERVAL - 1; end
      else m_wait--;
    end
    if (ab) begin
      a_aborts = satAdd(a_aborts, 1, CNT_MAX);
      m_armed = 0; m_track = 0; m_wait = INTERVAL - 1;
    end
    a_sat = a_sat || (a_sum_dp == ACC_MAX) || (a_sum_end == ACC_MAX) ||
            (a_samples == CNT_MAX) || (a_aborts == CNT_MAX);
    if (rd) begin
      s.sum_dp = a_sum_dp; s.sum_end = a_sum_end; s.max_end = a_max;
      s.samples = a_samples; s.aborts = a_aborts; s.sat = a_sat;
      exp_q.push_back(s);
      a_sum_dp = 0; a_sum_end = 0; a_max = 0; a_samples = 0; a_aborts = 0; a_sat = 0;
    end
  endfunction

  // Called at a negedge: drive one cycle of inputs, check busy, advance model.
  // Argument order: en, disp_valid, disp_idx, exec_valid, exec_idx, ret_valid, ret_idx, flush, rd_req
  task automatic applyStimulus(input bit en, input bit dv, input int di, input bit xv, input int xi,
                               input bit rv, input int ri, input bit fl, input bit rd);
    bus.en         = en;
    bus.timestamp  = DUR_W'(ts_now & MASK);
    bus.disp_valid = dv;
    bus.disp_idx   = IDX_W'(di);
    bus.exec_valid = xv;
    bus.exec_idx   = IDX_W'(xi);
    bus.ret_valid  = rv;
    bus.ret_idx    = IDX_W'(ri);
    bus.flush      = fl;
    bus.rd_req     = rd;
    checkOutput("busy", {31'b0, bus.busy}, {31'b0, (m_armed || m_track || m_commit)});
    modelStep(en, dv, di, xv, xi, rv, ri, fl, rd, ts_now & MASK);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readStats();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic runUntilArmed();
    for (int i = 0; i < 2 * INTERVAL + 4; i++) begin
      if (m_armed) break;
      idle(1);
    end
    checkOutput("arm_reached", {31'b0, m_armed}, 32'd1);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.timestamp  = '0;
    bus.disp_valid = 1'b0;
    bus.disp_idx   = '0;
    bus.exec_valid = 1'b0;
    bus.exec_idx   = '0;
    bus.ret_valid  = 1'b0;
    bus.ret_idx    = '0;
    bus.flush      = 1'b0;
    bus.rd_req     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("reset_busy",       {31'b0, bus.busy}, 32'd0);
    checkOutput("reset_rd_valid",   {31'b0, bus.rd_valid}, 32'd0);
    checkOutput("reset_rd_sum_dp",  32'(bus.rd_sum_dp), 32'd0);
    checkOutput("reset_rd_sum_end", 32'(bus.rd_sum_end), 32'd0);
    checkOutput("reset_rd_max_end", 32'(bus.rd_max_end), 32'd0);
    checkOutput("reset_rd_samples", 32'(bus.rd_samples), 32'd0);
    checkOutput("reset_rd_aborts",  32'(bus.rd_aborts), 32'd0);
    checkOutput("reset_rd_sat",     {31'b0, bus.rd_sat}, 32'd0);
  endtask

  // Monitor: every rd_valid pulse must match the oldest predicted snapshot.
  always @(negedge clk) begin
    if (!reset && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_rd_valid: got 1, want 0 (t=%0t)", $time);
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        checkOutput("rd_sum_dp",  32'(bus.rd_sum_dp),  32'(e.sum_dp));
        checkOutput("rd_sum_end", 32'(bus.rd_sum_end), 32'(e.sum_end));
        checkOutput("rd_max_end", 32'(bus.rd_max_end), 32'(e.max_end));
        checkOutput("rd_samples", 32'(bus.rd_samples), 32'(e.samples));
        checkOutput("rd_aborts",  32'(bus.rd_aborts),  32'(e.aborts));
        checkOutput("rd_sat",     {31'b0, bus.rd_sat}, {31'b0, e.sat});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    doReset();

    $display("[TB] basic sample");
    runUntilArmed();
    ts_now = 100; applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0);
    ts_now = 105; idle(1);
    ts_now = 112; applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 0);
    ts_now = 120; idle(1);
    ts_now = 130; applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0);
    ts_now = 131; idle(1);
    readStats();
    idle(1);

    $display("[TB] timestamp wrap");
    runUntilArmed();
    ts_now = 1020; applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0);
    ts_now = 3;    applyStimulus(1, 0, 0, 1, 7, 0, 0, 0, 0);
    ts_now = 9;    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
    idle(1);
    readStats();
    idle(1);

    $display("[TB] same-cycle exec+retire, read in commit cycle, back-to-back read");
    runUntilArmed();
    ts_now = 100; applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0);
    ts_now = 120; applyStimulus(1, 0, 0, 1, 5, 1, 5, 0, 0);
    readStats();
    readStats();
    idle(1);

    $display("[TB] retire before exec");
    runUntilArmed();
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0, 0);
    idle(2);
    readStats();
    idle(1);

    $display("[TB] flush precedence and idle flush");
    runUntilArmed();
    ts_now = 200; applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0);
    ts_now = 210; applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 0);
    ts_now = 220; applyStimulus(1, 0, 0, 0, 0, 1, 3, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    readStats();
    idle(1);

    $display("[TB] en dropped while armed, lost entry");
    runUntilArmed();
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0);
    runUntilArmed();
    ts_now = 300; applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin ts_now++; idle(1); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
    readStats();
    idle(1);

    $display("[TB] reset mid-sample");
    runUntilArmed();
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 2, 0, 0, 0, 0);
    @(negedge clk);
    doReset();
    readStats();
    idle(1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 6000; i++) begin
      bit en, dv, xv, rv, fl, rd;
      int di, xi, ri;
      ts_now = (ts_now + int'($urandom_range(0, 15))) & MASK;
      en = ($urandom_range(0, 15) != 0);
      dv = ($urandom_range(0, 2) == 0);
      di = int'($urandom_range(0, 3));
      xv = ($urandom_range(0, 3) == 0);
      xi = int'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) == 0);
      ri = int'($urandom_range(0, 3));
      fl = ($urandom_range(0, 40) == 0);
      rd = ($urandom_range(0, 300) == 0);
      applyStimulus(en, dv, di, xv, xi, rv, ri, fl, rd);
    end
    readStats();

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lq_sample_ctrl.md
# lq_sample_ctrl

Sampling controller for load-queue residency measurement in the AVF cross-layer monitor. Every `INTERVAL` idle cycles it arms, latches the next dispatched load's LQ index and dispatch timestamp, and tracks that entry to execute and to retire. It accumulates dispatch→exec and dispatch→retire durations into saturating statistics. Software-side logic drains the statistics through a one-shot read handshake, which also clears them.

## Interface
- `DUR_W`, 10: timestamp and duration width, in coarse ticks.
- `IDX_W`, 6: LQ index width.
- `ACC_W`, 24: duration accumulator width.
- `CNT_W`, 16: event counter width.
- `INTERVAL`, 256: idle cycles between samples. Must be ≥2.
- `TIMEOUT`, 1023: abort threshold, in cycles spent tracking.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `en` in 1: permits new samples to arm.
- `timestamp` in DUR_W: free-running coarse time. Wraps.
- `disp_valid` in 1, `disp_idx` in IDX_W: load dispatch.
- `exec_valid` in 1, `exec_idx` in IDX_W: load execute.
- `ret_valid` in 1, `ret_idx` in IDX_W: load retire.
- `flush` in 1: pipeline flush.
- `rd_req` in 1: single-cycle read request.
- `busy` out 1: state ≠ IDLE.
- `rd_valid` out 1: single-cycle pulse, one cycle after `rd_req`.
- `rd_sum_dp` out ACC_W, `rd_sum_end` out ACC_W: duration sums.
- `rd_max_end` out DUR_W: largest dispatch→retire duration.
- `rd_samples` out CNT_W, `rd_aborts` out CNT_W: event counts.
- `rd_sat` out 1: any accumulator or counter hit all-ones.

## Operation
- FSM states: IDLE, ARM, WAIT_EXEC, WAIT_RET, COMMIT.
- IDLE
  - Interval counter decrements while `en` is high. It holds while `en` is low.
  - At 0 with `en` high, go to ARM and reload the counter to `INTERVAL-1`.
- ARM
  - On `disp_valid`: latch `start=timestamp` and `mon_idx=disp_idx`, then go to WAIT_EXEC.
  - Dropping `en` in ARM returns the FSM to IDLE.
- WAIT_EXEC
  - Exec match (`exec_valid && exec_idx==mon_idx`): `dur_dp = timestamp-start` mod 2^DUR_W, then go to WAIT_RET.
  - Exec and retire match in the same cycle: `dur_dp = dur_end` = that value, then go to COMMIT.
  - Retire match without a prior exec: abort.
- WAIT_RET
  - Retire match: `dur_end = timestamp-start` mod 2^DUR_W, then go to COMMIT.
  - Further exec matches (replays) are ignored.
- COMMIT (one cycle)
  - `sum_dp += dur_dp` and `sum_end += dur_end`, each saturating at all-ones.
  - `samples += 1`, saturating.
  - `max_end = max(max_end, dur_end)`.
  - Return to IDLE.
- Abort
  - Triggered by `flush` in ARM, WAIT_EXEC or WAIT_RET; by a retire-before-exec; or by a timeout.
  - `aborts += 1` (saturating), return to IDLE, accumulators unchanged.
  - `flush` in IDLE or COMMIT has no effect. A COMMIT in progress completes.
- `flush` has priority over a same-cycle match.
- `sat` is sticky and set when any of the four accumulators/counters reaches all-ones. It clears only on read or reset.
- Read
  - `rd_req` in cycle N: the `rd_*` registers load the post-update values of cycle N, including any COMMIT or abort in cycle N.
  - All accumulators, counters, `max_end` and `sat` clear to 0 at the end of cycle N.
  - `rd_valid`=1 in cycle N+1 only.
  - `rd_*` data holds until the next read.
  - `rd_req` on consecutive cycles is legal; the second read returns only cycle N+1 activity.
- The FSM is unaffected by reads.
- A retire coinciding with wrap of `timestamp` yields the correct modular duration. True durations ≥2^DUR_W alias; this is accepted.

## Timing
- Reset values
  - FSM in IDLE; interval counter = `INTERVAL-1`; all accumulators 0.
  - `busy`=0, `rd_valid`=0, all `rd_*`=0, `rd_sat`=0.
- With `en` held high from reset release (cycle 0), the FSM enters ARM in cycle `INTERVAL`.
- Dispatch in cycle D leaves ARM; `busy` stays 1.
- Latency to COMMIT is 1 cycle after the retire match. The FSM is in IDLE 2 cycles after the match.
- Interval counting resumes from a full reload after every COMMIT or abort.
- `reset` asserted mid-sample discards the sample; nothing is committed.
- Outputs are registered.

## Configuration
- `LQ_SAMPLE_TIMEOUT_EN` defined
  - A tracking counter clears on entry to WAIT_EXEC and increments in WAIT_EXEC and WAIT_RET.
  - When it reaches `TIMEOUT` without a match, the sample aborts (counted in `aborts`).
- `LQ_SAMPLE_TIMEOUT_EN` undefined
  - No tracking counter.
  - A lost entry stalls the FSM in WAIT_* until `flush` or `reset`.

## Test plan
- Basic sample, `INTERVAL`=4
  - Stimulus: dispatch idx 5 at ts 100; exec idx 5 at ts 112; retire at ts 130; then `rd_req`.
  - Required: `rd_sum_dp`=12, `rd_sum_end`=30, `rd_max_end`=30, `rd_samples`=1, `rd_aborts`=0.
- Wrap
  - Stimulus: dispatch at ts 1020; exec at ts 3; retire at ts 9.
  - Required: `dur_dp`=7, `dur_end`=13.
- Same-cycle exec+retire
  - Stimulus: exec and retire for idx 5 in the same cycle at ts 120, dispatch at ts 100.
  - Required: both sums are 20.
- Retire-before-exec
  - Stimulus: retire for the monitored idx arrives first.
  - Required: `aborts`=1, `samples`=0, `busy` drops 1 cycle later.
- Flush precedence
  - Stimulus: `flush` in WAIT_RET coincident with a retire match.
  - Required: abort counted, sums unchanged.
  - Stimulus: `flush` in IDLE.
  - Required: no change.
- Read/commit collision plus timeout
  - Stimulus: `rd_req` in the COMMIT cycle.
  - Required: snapshot includes that sample, next read returns zeros, `rd_sat`=0.
  - Stimulus: with `LQ_SAMPLE_TIMEOUT_EN` defined and `TIMEOUT`=16, withhold exec.
  - Required: abort 16 cycles after entering WAIT_EXEC.
